instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Front-end instruction fetch stage for the vector ASIP pipeline. Generates sequential PCs, issues in-order reads to instruction memory, buffers returned words in a small slot queue, and drives the fetch/decode pipeline register with `curr_pc` plus the raw 32-bit instruction `ACIns`. Handles jump redirects by flushing buffered and in-flight fetches and injecting NOP bubbles.

## Interface
Parameters:
- `DEPTH`, 2: slot count; power of two, ≥2. Caps outstanding plus buffered fetches.
- `NOP_WORD`, 32'h2000_0000: bubble word (op=0, inst=2'b10, remaining fields 0).

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `jmp_en`  in  1  redirect request; 1-cycle pulse.
- `jmp_target`  in  32  redirect PC; bits [1:0] forced to 0.
- `stall`  in  1  downstream hold; output register keeps its value.
- `imem_req`  out  1  read request; memory accepts every request.
- `imem_addr`  out  32  word-aligned read address.
- `imem_rvalid`  in  1  read data valid; responses return in order, latency ≥1 cycle, variable.
- `imem_rdata`  in  32  read data.
- `curr_pc`  out  32  PC of `ACIns`.
- `ACIns`  out  32  instruction word to the pipeline register.
- `ins_valid`  out  1  `ACIns` is a real fetched instruction, not a bubble.
- `fetch_err`  out  1  sticky; response arrived with nothing outstanding.

## Operation
- Reset values: `pc_q`=0, slot queue empty, outstanding=0, drop_cnt=0, `curr_pc`=0, `ACIns`=`NOP_WORD`, `ins_valid`=0, `fetch_err`=0, `imem_req`=0.
- Slot allocation: a slot is allocated at issue, holding the request PC; data is filled on `imem_rvalid`. Head is poppable once filled.
- Issue: `imem_req`=1 (combinational) when !`rst`, !`jmp_en`, and occupied slots minus pop-this-cycle < `DEPTH`. `imem_addr`=`pc_q`. On issue, `pc_q` += 4, wrapping 32'hFFFF_FFFC → 0.
- Output update, when !`stall`:
  - head filled: pop; `curr_pc`←slot PC, `ACIns`←slot data, `ins_valid`←1.
  - otherwise: `ACIns`←`NOP_WORD`, `ins_valid`←0, `curr_pc` held.
- When `stall`=1: output register, head, and pop are all held. Issue and response fill continue until slots are exhausted.
- Jump (`jmp_en`=1, priority over `stall`; `rst` has priority over jump):
  - `pc_q`←`jmp_target`&~3.
  - All slots cleared.
  - drop_cnt←(issued-but-unreturned count) − `imem_rvalid`.
  - Output←`NOP_WORD`, `ins_valid`←0; `curr_pc` held.
  - No issue in the jump cycle. A response in the jump cycle is discarded.
- Drop: while drop_cnt>0, each `imem_rvalid` is discarded and decrements drop_cnt. These responses are not written to any slot.
- `fetch_err` is set when `imem_rvalid`=1 with no unreturned request and drop_cnt=0. The response is ignored. The flag clears only on `rst`.
- Back-to-back jumps: each jump recomputes drop_cnt from the current drop_cnt plus unreturned live requests.

## Timing
- Memory latency L: request issued in cycle c is visible on `ACIns` from cycle c+L+2, absent stall.
- Full throughput with L=1 and `DEPTH`=2: 1 instruction/cycle.
- After `rst` is released in cycle r:
  - first issue in cycle r (addr 0).
  - with L=1, `ACIns`=mem[0], `ins_valid`=1 visible in cycle r+3.
- Jump in cycle j:
  - NOP visible at j+1.
  - first target request issued at j+1.
  - target instruction visible at j+L+3.
- `rst` mid-operation discards everything, including later responses to pre-reset requests. The memory side is reset in the same cycle by system convention.

## Structure
- Package `fetch_pkg`:
  - `NOP_WORD`.
  - field position localparams: op[31:30], inst[29:28], flagV[27], R3[11:8], R2[7:4], R1[3:0], Imme[26:0].
  - `typedef struct packed {logic [31:0] pc; logic [31:0] word; logic filled;} fetch_slot_t`.
- Sub-module `fetch_slot_queue`: circular buffer of `fetch_slot_t` with alloc/fill/pop/flush. Alloc pointer, fill pointer, and pop pointer are each log2(`DEPTH`)+1 bits.
- Top level holds `pc_q`, outstanding/drop counters, issue logic, output register, and `fetch_err`.

## Test plan
- Reset/stream: L=1 memory, mem[k]=32'hA000_0000+k. `rst` for 2 cycles, then release → `ACIns` = A000_0000, A000_0001, … on consecutive cycles from r+3; `curr_pc` = 0, 4, 8, …; `ins_valid`=1.
- Stall: assert `stall` for 4 cycles mid-stream → `ACIns`/`curr_pc` frozen, at most `DEPTH` requests outstanding. On release, resumes with no lost or duplicated word.
- Jump with in-flight requests: L=3 memory, `jmp_en` with `jmp_target`=32'h0000_0103 while 2 requests are in flight.
  - the 2 stale responses are dropped.
  - `ACIns`=`NOP_WORD`, `ins_valid`=0 until the first word from 0x100 appears with `curr_pc`=0x100.
- Jump + stall + rvalid in the same cycle: the jump wins, that response is discarded, drop_cnt is correct, and there is no `fetch_err`.
- Wrap: redirect to 32'hFFFF_FFF8 → `imem_addr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Protocol error: inject `imem_rvalid` with nothing outstanding → `fetch_err`=1, output unchanged; cleared only by `rst`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   NOP_WORD      : bubble instruction injected when no fetched word is ready
//   field ranges  : bit positions of the ASIP instruction fields
//   fetch_slot_t  : one slot of the fetch buffer (request PC, data, filled flag)
//   align_pc      : clears the two low PC bits
//   next_pc       : sequential successor, wrapping 32'hFFFF_FFFC -> 0
package fetch_pkg;

    localparam logic [31:0] NOP_WORD = 32'h2000_0000;

    // Instruction field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 30;
    localparam int INST_MSB  = 29;
    localparam int INST_LSB  = 28;
    localparam int FLAGV_BIT = 27;
    localparam int IMME_MSB  = 26;
    localparam int IMME_LSB  = 0;
    localparam int R3_MSB    = 11;
    localparam int R3_LSB    = 8;
    localparam int R2_MSB    = 7;
    localparam int R2_LSB    = 4;
    localparam int R1_MSB    = 3;
    localparam int R1_LSB    = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        filled;
    } fetch_slot_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // 32-bit addition wraps naturally from the last word back to 0
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// Circular buffer of fetch slots. A slot is allocated when a read is issued
// (capturing its PC), filled in order as read data returns, and popped from
// the head once filled. Flush drops every slot at once.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : clear all slots and pointers
//   alloc, alloc_pc    : allocate a slot for a newly issued request
//   fill, fill_data    : write returned data into the oldest unfilled slot
//   pop                : remove the head slot
//   head_filled        : head slot exists and holds data
//   head_pc, head_word : contents of the head slot
//   count              : number of allocated slots
module fetch_slot_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [31:0]              alloc_pc,
    input  logic                     fill,
    input  logic [31:0]              fill_data,
    input  logic                     pop,
    output logic                     head_filled,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_word,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] PTR_ZERO = {(PW+1){1'b0}};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PW:0]  alloc_ptr_r;
    logic [PW:0]  fill_ptr_r;
    logic [PW:0]  pop_ptr_r;
    fetch_slot_t  slots_r [DEPTH];
    fetch_slot_t  head_s;

    assign count       = alloc_ptr_r - pop_ptr_r;
    assign head_s      = slots_r[pop_ptr_r[PW-1:0]];
    // The filled flag of a free slot is stale, so gate it with occupancy
    assign head_filled = (count != PTR_ZERO) && head_s.filled;
    assign head_pc     = head_s.pc;
    assign head_word   = head_s.word;

    // Slot storage and pointer updates
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alloc_ptr_r <= PTR_ZERO;
            fill_ptr_r  <= PTR_ZERO;
            pop_ptr_r   <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '{pc: 32'h0, word: 32'h0, filled: 1'b0};
            end
        end else begin
            // When full, alloc reuses the slot being popped this same cycle;
            // the head is read combinationally before this write lands.
            if (alloc) begin
                slots_r[alloc_ptr_r[PW-1:0]] <= '{pc: alloc_pc, word: 32'h0, filled: 1'b0};
                alloc_ptr_r <= alloc_ptr_r + PTR_ONE;
            end
            if (fill) begin
                slots_r[fill_ptr_r[PW-1:0]].word   <= fill_data;
                slots_r[fill_ptr_r[PW-1:0]].filled <= 1'b1;
                fill_ptr_r <= fill_ptr_r + PTR_ONE;
            end
            if (pop) begin
                pop_ptr_r <= pop_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues sequential in-order reads, buffers returned
// words, and loads the fetch/decode register. Jumps flush buffered and
// in-flight fetches; late responses to flushed requests are counted off.
//   clk, rst                : clock, synchronous active-high reset
//   jmp_en, jmp_target      : one-cycle redirect request and target PC
//   stall                   : hold the output register
//   imem_req, imem_addr     : read request to instruction memory
//   imem_rvalid, imem_rdata : in-order read response
//   curr_pc, ACIns          : PC and instruction presented to decode
//   ins_valid               : ACIns is a fetched instruction, not a bubble
//   fetch_err               : sticky, response arrived with nothing pending
module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_en,
    input  logic [31:0] jmp_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] curr_pc,
    output logic [31:0] ACIns,
    output logic        ins_valid,
    output logic        fetch_err
);

    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    // Drops can accumulate across repeated jumps against a slow memory
    localparam int DW = 16;
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(DEPTH);
    localparam logic [PW:0]   LIVE_ZERO = {(PW+1){1'b0}};
    localparam logic [DW-1:0] DROP_ZERO = {DW{1'b0}};

    logic [31:0]   pc_q;
    logic [PW:0]   live_r;       // issued, unreturned, still wanted
    logic [DW-1:0] drop_cnt_r;   // issued, unreturned, flushed by a jump

    logic          pop_s;
    logic          issue_s;
    logic          resp_drop_s;
    logic          resp_live_s;
    logic          resp_err_s;
    logic          head_filled_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_word_s;
    logic [PW:0]   q_count_s;

    assign pop_s   = !rst && !jmp_en && !stall && head_filled_s;
    // A slot freed by this cycle's pop can be reallocated immediately
    assign issue_s = !rst && !jmp_en && ((q_count_s - {{PW{1'b0}}, pop_s}) < DEPTH_C);

    // Flushed responses are retired before any live one (in-order memory)
    assign resp_drop_s = imem_rvalid && (drop_cnt_r != DROP_ZERO);
    assign resp_live_s = imem_rvalid && (drop_cnt_r == DROP_ZERO) && (live_r != LIVE_ZERO);
    assign resp_err_s  = imem_rvalid && (drop_cnt_r == DROP_ZERO) && (live_r == LIVE_ZERO);

    assign imem_req  = issue_s;
    assign imem_addr = pc_q;

    fetch_slot_queue #(.DEPTH(DEPTH)) u_slots (
        .clk         (clk),
        .rst         (rst),
        .flush       (jmp_en),
        .alloc       (issue_s),
        .alloc_pc    (pc_q),
        .fill        (resp_live_s && !jmp_en),
        .fill_data   (imem_rdata),
        .pop         (pop_s),
        .head_filled (head_filled_s),
        .head_pc     (head_pc_s),
        .head_word   (head_word_s),
        .count       (q_count_s)
    );

    // Fetch PC, request accounting and protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= 32'h0;
            live_r     <= LIVE_ZERO;
            drop_cnt_r <= DROP_ZERO;
            fetch_err  <= 1'b0;
        end else begin
            if (resp_err_s) begin
                fetch_err <= 1'b1;
            end
            if (jmp_en) begin
                pc_q   <= align_pc(jmp_target);
                live_r <= LIVE_ZERO;
                // Every request still out becomes a drop; this cycle's
                // response (if any) is consumed from whichever pool owns it.
                drop_cnt_r <= drop_cnt_r
                              + {{(DW-PW-1){1'b0}}, live_r}
                              - {{(DW-1){1'b0}}, resp_drop_s}
                              - {{(DW-1){1'b0}}, resp_live_s};
            end else begin
                if (issue_s) begin
                    pc_q <= next_pc(pc_q);
                end
                live_r     <= live_r + {{PW{1'b0}}, issue_s} - {{PW{1'b0}}, resp_live_s};
                drop_cnt_r <= drop_cnt_r - {{(DW-1){1'b0}}, resp_drop_s};
            end
        end
    end

    // Fetch/decode pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_pc   <= 32'h0;
            ACIns     <= NOP_WORD;
            ins_valid <= 1'b0;
        end else if (jmp_en) begin
            ACIns     <= NOP_WORD;
            ins_valid <= 1'b0;
        end else if (!stall) begin
            if (head_filled_s) begin
                curr_pc   <= head_pc_s;
                ACIns     <= head_word_s;
                ins_valid <= 1'b1;
            end else begin
                ACIns     <= NOP_WORD;
                ins_valid <= 1'b0;
            end
        end
    end

endmodule
